// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NUM_CH-to-1 valid/ready stream mux with manual or round-robin source select
// and one registered output stage. Optional packet lock enabled by STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [NUM_CH-1:0]       in_last,
    output logic                    out_last,
`endif
    input  logic                    auto,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0] rr_ptr;
    logic             load_en;
    logic             accept;
    logic             advance;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] next_ptr;
    logic             hi_found;
    logic [SEL_W-1:0] hi_idx;
    logic             lo_found;
    logic [SEL_W-1:0] lo_idx;
    logic             man_ok;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic             lock_active;
    logic [SEL_W-1:0] lock_ch;
    logic             grant_last;
`endif

    assign load_en = !out_valid || out_ready;

    // Lowest valid channel at or above rr_ptr, falling back to lowest overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (in_valid[SEL_W'(i)]) begin
                lo_found = 1'b1;
                lo_idx   = SEL_W'(i);
                if (SEL_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(i);
                end
            end
        end
    end

    assign man_ok = (32'(sel) < NUM_CH) && in_valid[sel];

    // Grant selection: packet lock (if built) overrides both arbitration modes.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_active) begin
            grant_vld = in_valid[lock_ch];
            grant_idx = lock_ch;
        end else
`endif
        if (auto) begin
            grant_vld = lo_found;
            grant_idx = hi_found ? hi_idx : lo_idx;
        end else if (man_ok) begin
            grant_vld = 1'b1;
            grant_idx = sel;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = in_data[i*int'(WIDTH) +: WIDTH];
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    assign grant_last = in_last[grant_idx];
`endif

    always_comb begin
        in_ready = '0;
        if (!rst && load_en && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign accept   = !rst && load_en && grant_vld;
    assign next_ptr = (grant_idx == LAST_CH) ? '0 : grant_idx + SEL_W'(1);

    // Pointer moves past the winner only for auto-mode grants (and only at packet end).
    always_comb begin
        advance = accept && auto;
`ifdef STREAM_MUX_PKT_LOCK_EN
        advance = advance && grant_last;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last    <= 1'b0;
            lock_active <= 1'b0;
            lock_ch     <= '0;
`endif
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
                out_last    <= grant_last;
                lock_active <= !grant_last;
                lock_ch     <= grant_idx;
`endif
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (advance) begin
                rr_ptr <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: scoreboard of expected output beats plus
// inline checks for reset, manual select, round-robin, back-pressure and boundaries.
module tb_stream_mux_rr;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned WIDTH  = 5;
    localparam int unsigned SEL_W  = 2;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] ch;
        logic             last;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic                    auto;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    logic [3*WIDTH-1:0]      in_data3;
    logic [2:0]              in_valid3;
    logic [2:0]              in_ready3;
    logic                    auto3;
    logic [1:0]              sel3;
    logic [WIDTH-1:0]        out_data3;
    logic [1:0]              out_ch3;
    logic                    out_valid3;
    logic                    out_ready3;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [NUM_CH-1:0]       in_last;
    logic                    out_last;
    logic [2:0]              in_last3;
    logic                    out_last3;
`endif

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t mon_exp;

    stream_mux_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SEL_W(SEL_W)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last(in_last), .out_last(out_last),
`endif
        .auto(auto), .sel(sel), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.NUM_CH(3), .WIDTH(WIDTH), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last(in_last3), .out_last(out_last3),
`endif
        .auto(auto3), .sel(sel3), .out_data(out_data3), .out_ch(out_ch3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    always #5 clk = ~clk;

    // Output monitor: a transfer happens at the coming posedge, compare it to the queue head.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra_beat: got data=%h ch=%0d, required no beat", out_data, out_ch);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp.data || out_ch !== mon_exp.ch) begin
                    errors++;
                    $display("FAIL scoreboard_beat: got data=%h ch=%0d, required data=%h ch=%0d",
                             out_data, out_ch, mon_exp.data, mon_exp.ch);
                end
`ifdef STREAM_MUX_PKT_LOCK_EN
                if (out_last !== mon_exp.last) begin
                    errors++;
                    $display("FAIL scoreboard_last: got %b, required %b", out_last, mon_exp.last);
                end
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] c, input logic l);
        exp_q.push_back('{data: d, ch: c, last: l});
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        step();
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got %0d pending beats out_valid=%b, required 0 and 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; auto = 1'b1; sel = '0; out_ready = 1'b1; in_valid = 4'hF;
        in_data = {5'h13, 5'h12, 5'h11, 5'h10};
        step();
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready: got %b, required 0000", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 5'h00 || out_ch !== 2'd0 || out_valid3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h ch=%0d valid3=%b, required 0 00 0 0",
                     out_valid, out_data, out_ch, out_valid3);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++; $display("FAIL reset_first_grant: got %b, required 0001", in_ready);
        end
        push(5'h10, 2'd0, 1'b1);
        step();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
            errors++; $display("FAIL reset_first_beat: got valid=%b ch=%0d, required 1 0", out_valid, out_ch);
        end
        drain();
    endtask

    task automatic manual_pass(input logic [NUM_CH*WIDTH-1:0] d);
        logic [WIDTH-1:0] e;
        in_data = d;
        for (int k = 0; k < 4; k++) begin
            sel = SEL_W'(k);
            e   = d[k*5 +: 5];
            push(e, SEL_W'(k), 1'b1);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== e || out_ch !== SEL_W'(k)) begin
                errors++;
                $display("FAIL manual_sel%0d: got valid=%b data=%h ch=%0d, required 1 %h %0d",
                         k, out_valid, out_data, out_ch, e, k);
            end
        end
    endtask

    task automatic test_manual();
        auto = 1'b0; out_ready = 1'b1; in_valid = 4'hF;
        manual_pass({5'h03, 5'h02, 5'h01, 5'h00});
        manual_pass({5'h0A, 5'h05, 5'h0A, 5'h05});
        drain();
    endtask

    task automatic test_round_robin();
        logic [1:0] c;
        logic [NUM_CH*WIDTH-1:0] d;
        rst = 1'b1;
        step();
        rst = 1'b0; auto = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
        d = {5'h1B, 5'h1A, 5'h19, 5'h18};
        in_data = d;
        for (int i = 0; i < 8; i++) begin
            c = 2'(i % 4);
            push(d[c*5 +: 5], c, 1'b1);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== c) begin
                errors++; $display("FAIL rr_all_%0d: got ch=%0d valid=%b, required ch=%0d", i, out_ch, out_valid, c);
            end
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            c = (i % 2 == 1) ? 2'd3 : 2'd1;
            push(d[c*5 +: 5], c, 1'b1);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== c) begin
                errors++; $display("FAIL rr_odd_%0d: got ch=%0d valid=%b, required ch=%0d", i, out_ch, out_valid, c);
            end
        end
        drain();
    endtask

    task automatic test_back_pressure();
        auto = 1'b0; sel = 2'd1; out_ready = 1'b1; in_valid = 4'b0010;
        in_data = {5'h00, 5'h00, 5'h0A, 5'h00};
        push(5'h0A, 2'd1, 1'b1);
        step();
        out_ready = 1'b0;
        in_data = {5'h00, 5'h00, 5'h15, 5'h00};
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_in_ready_%0d: got %b, required 0000", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 5'h0A) begin
                errors++; $display("FAIL bp_hold_%0d: got valid=%b data=%h, required 1 0a", i, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        push(5'h15, 2'd1, 1'b1);
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_release_ready: got %b, required 0010", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 5'h15) begin
            errors++; $display("FAIL bp_no_bubble: got valid=%b data=%h, required 1 15", out_valid, out_data);
        end
        drain();
    endtask

    task automatic test_boundary_sel();
        auto3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1; in_valid3 = 3'b111;
        in_data3 = {5'h07, 5'h06, 5'h05};
        step();
        checks++;
        if (out_valid3 !== 1'b1 || out_data3 !== 5'h05 || out_ch3 !== 2'd0) begin
            errors++; $display("FAIL bnd_first: got valid=%b data=%h ch=%0d, required 1 05 0", out_valid3, out_data3, out_ch3);
        end
        sel3 = 2'd3;
        #1;
        checks++;
        if (in_ready3 !== 3'b000) begin
            errors++; $display("FAIL bnd_sel_oob_ready: got %b, required 000", in_ready3);
        end
        step();
        checks++;
        if (out_valid3 !== 1'b0 || out_data3 !== 5'h05) begin
            errors++; $display("FAIL bnd_drain: got valid=%b data=%h, required 0 05", out_valid3, out_data3);
        end
        step();
        checks++;
        if (out_valid3 !== 1'b0) begin
            errors++; $display("FAIL bnd_idle: got valid=%b, required 0", out_valid3);
        end
        in_valid3 = '0;
    endtask

    task automatic test_mid_reset();
        auto = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
        in_data = {5'h1D, 5'h1C, 5'h1B, 5'h1A};
        push(5'h1A, 2'd0, 1'b1);
        step();
        step();
        rst = 1'b1; out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL midrst_in_ready: got %b, required 0000", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_valid: got %b, required 0", out_valid);
        end
        rst = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++; $display("FAIL midrst_grant: got %b, required 0001", in_ready);
        end
        push(5'h1A, 2'd0, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
            errors++; $display("FAIL midrst_beat: got valid=%b ch=%0d, required 1 0", out_valid, out_ch);
        end
        drain();
    endtask

`ifdef STREAM_MUX_PKT_LOCK_EN
    task automatic test_pkt_lock();
        logic [1:0] exp_ch [4];
        exp_ch[0] = 2'd2; exp_ch[1] = 2'd2; exp_ch[2] = 2'd2; exp_ch[3] = 2'd0;
        auto = 1'b1; out_ready = 1'b1;
        in_valid = 4'b0101; in_last = 4'b1011;
        in_data = {5'h00, 5'h12, 5'h04, 5'h03};
        push(5'h12, 2'd2, 1'b0);
        step();
        in_valid = 4'b0111;
        in_data = {5'h00, 5'h13, 5'h04, 5'h03};
        push(5'h13, 2'd2, 1'b0);
        step();
        in_last = 4'b1111;
        in_data = {5'h00, 5'h14, 5'h04, 5'h03};
        push(5'h14, 2'd2, 1'b1);
        step();
        in_valid = 4'b0011;
        push(5'h03, 2'd0, 1'b1);
        step();
        checks++;
        if (out_ch !== exp_ch[3]) begin
            errors++; $display("FAIL pkt_after_release: got ch=%0d, required %0d", out_ch, exp_ch[3]);
        end
        drain();
    endtask
`endif

    initial begin
        rst = 1'b1; auto = 1'b1; sel = '0; out_ready = 1'b1; in_valid = '0; in_data = '0;
        auto3 = 1'b0; sel3 = '0; out_ready3 = 1'b1; in_valid3 = '0; in_data3 = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        in_last = '1; in_last3 = '1;
`endif
        test_reset();
        test_manual();
        test_round_robin();
        test_back_pressure();
        test_boundary_sel();
        test_mid_reset();
`ifdef STREAM_MUX_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
